// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: control/status bundle between the reset sequencer and its subsystems
//   soft_rst_req_in  restart request pulse, into the sequencer
//   stage_done_in    per-stage init-done levels, into the sequencer
//   stage_rst_out    per-stage active-high resets, from the sequencer
//   sys_ready_out    all stages up, from the sequencer
//   seq_error_out    sticky error, from the sequencer
//   seq_state_out    FSM state code, from the sequencer
interface reset_sequencer_if #(parameter int NUM_STAGES = 3);
    logic                  soft_rst_req_in;
    logic [NUM_STAGES-1:0] stage_done_in;
    logic [NUM_STAGES-1:0] stage_rst_out;
    logic                  sys_ready_out;
    logic                  seq_error_out;
    logic [2:0]            seq_state_out;
    modport master (
        output soft_rst_req_in, stage_done_in,
        input  stage_rst_out, sys_ready_out, seq_error_out, seq_state_out
    );
    modport slave (
        input  soft_rst_req_in, stage_done_in,
        output stage_rst_out, sys_ready_out, seq_error_out, seq_state_out
    );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases per-subsystem resets in order, each gated by the previous stage's done
//   sys_clk_in    system clock
//   sys_rst_n_in  async active-low reset, released through a 2-FF synchronizer
//   bus           reset_sequencer_if.slave: soft restart, stage done in; resets, ready, error, state out
module reset_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGE_GAP      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              sys_clk_in,
    input logic              sys_rst_n_in,
    reset_sequencer_if.slave bus
);
    localparam logic [2:0] HOLD = 3'd0, WAIT_DONE = 3'd1, GAP = 3'd2, READY = 3'd3, ERROR = 3'd4;
    localparam int MAXC = TIMEOUT_CYCLES > HOLD_CYCLES
        ? (TIMEOUT_CYCLES > STAGE_GAP ? TIMEOUT_CYCLES : STAGE_GAP)
        : (HOLD_CYCLES > STAGE_GAP ? HOLD_CYCLES : STAGE_GAP);
    localparam int CW = $clog2(MAXC + 1);
    localparam int KW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
    logic [1:0]            sync_q;
    logic [2:0]            state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [NUM_STAGES-1:0] rel, stage_rst_q, stage_rst_d;
    logic                  ready_q, ready_d, error_q, error_d, restart;
    always_ff @(posedge sys_clk_in or negedge sys_rst_n_in)
        if (!sys_rst_n_in) sync_q <= '0;
        else sync_q <= {sync_q[0], 1'b1};
    // Until the synchronizer releases, the FSM is held exactly as a soft restart would hold it.
    assign restart = bus.soft_rst_req_in || !sync_q[1];
    always_comb begin
        cnt_inc = &cnt_q ? cnt_q : cnt_q + CW'(1);
        for (int i = 0; i < NUM_STAGES; i++) rel[i] = i <= int'(k_q);
        state_d = state_q;
        k_d     = k_q;
        if (restart) begin
            state_d = HOLD;
            k_d     = '0;
        end else case (state_q)
            HOLD: if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                state_d = WAIT_DONE;
                k_d     = '0;
            end
            WAIT_DONE:
                if (bus.stage_done_in[k_q]) state_d = int'(k_q) == NUM_STAGES - 1 ? READY : GAP;
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
            GAP:
                if ((bus.stage_done_in & rel) != rel) state_d = ERROR;
                else if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    state_d = WAIT_DONE;
                    k_d     = k_q + KW'(1);
                end
            READY: if (!(&bus.stage_done_in)) state_d = ERROR;
            default: state_d = ERROR;
        endcase
        cnt_d = (restart || state_d != state_q) ? '0 : cnt_inc;
    end
    // Outputs are computed from the next state so the registered copies change on the entry edge.
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++)
            stage_rst_d[i] = (state_d == WAIT_DONE || state_d == GAP) ? i > int'(k_d) : state_d != READY;
        ready_d = state_d == READY;
        error_d = state_d == ERROR;
    end
    always_ff @(posedge sys_clk_in or negedge sys_rst_n_in)
        if (!sys_rst_n_in) begin
            state_q     <= HOLD;
            k_q         <= '0;
            cnt_q       <= '0;
            stage_rst_q <= '1;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            stage_rst_q <= stage_rst_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    assign bus.stage_rst_out = stage_rst_q;
    assign bus.sys_ready_out = ready_q;
    assign bus.seq_error_out = error_q;
    assign bus.seq_state_out = state_q;
endmodule
